// File: rtl/dm_cache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// dm_cache_ctrl : direct-mapped read-only cache controller with line refill
// Rev 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int INDEX_BITS  = 8,
   parameter int OFFSET_BITS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ready,
   output logic              cpu_resp_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = 1 << OFFSET_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      REFILL  = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [OFFSET_BITS-1:0] beat_q, beat_d;
   logic [31:0]         hit_q, hit_d, miss_q, miss_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [LINES-1:0]    valid_q, valid_d;

   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [LINES*WORDS];

   logic [TAG_W-1:0]       req_tag;
   logic [INDEX_BITS-1:0]  req_idx;
   logic [OFFSET_BITS-1:0] req_off;
   logic                   lookup_hit;
   logic                   data_wr_en;
   logic                   line_fill_en;
   logic [DATA_W-1:0]      rd_word;

   assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx    = addr_q[OFFSET_BITS +: INDEX_BITS];
   assign req_off    = addr_q[OFFSET_BITS-1:0];
   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign rd_word    = data_mem[{req_idx, req_off}];

   assign mem_addr   = mem_addr_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      mem_addr_d     = mem_addr_q;
      beat_d         = beat_q;
      hit_d          = hit_q;
      miss_d         = miss_q;
      rdata_d        = rdata_q;
      valid_d        = valid_q;
      data_wr_en     = 1'b0;
      line_fill_en   = 1'b0;
      cpu_ready      = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_rdata      = rdata_q;
      mem_req        = 1'b0;
      case (state_q)
         IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) begin
               addr_d  = cpu_addr;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (lookup_hit) begin
               hit_d   = hit_q + 32'd1;
               state_d = RESPOND;
            end else begin
               miss_d     = miss_q + 32'd1;
               mem_addr_d = {addr_q[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               beat_d     = '0;
               state_d    = REFILL;
            end
         end
         REFILL: begin
            mem_req = 1'b1;
            if (mem_valid) begin
               data_wr_en = 1'b1;
               beat_d     = beat_q + 1'b1;
               // Tag/valid commit together with the final word so a partial line is never visible.
               if (beat_q == {OFFSET_BITS{1'b1}}) begin
                  line_fill_en     = 1'b1;
                  valid_d[req_idx] = 1'b1;
                  state_d          = RESPOND;
               end
            end
         end
         RESPOND: begin
            cpu_resp_valid = 1'b1;
            cpu_rdata      = rd_word;
            rdata_d        = rd_word;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         mem_addr_q <= '0;
         beat_q     <= '0;
         hit_q      <= '0;
         miss_q     <= '0;
         rdata_q    <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         mem_addr_q <= mem_addr_d;
         beat_q     <= beat_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         rdata_q    <= rdata_d;
         valid_q    <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && data_wr_en)
         data_mem[{req_idx, beat_q}] <= mem_rdata;
      if (!reset && line_fill_en)
         tag_mem[req_idx] <= req_tag;
   end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dm_cache_ctrl : directed + randomized check of dm_cache_ctrl
// Rev 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cpu_ready;
   logic        cpu_resp_valid;
   logic [31:0] cpu_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int vectors    = 0;
   int miscompares = 0;

   // Reference cache state: which line holds which tag, plus expected counters.
   logic        m_valid [256];
   logic [19:0] m_tag   [256];
   logic [31:0] m_hits;
   logic [31:0] m_misses;

   dm_cache_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cpu_addr       (cpu_addr),
      .cpu_ready      (cpu_ready),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_rdata      (cpu_rdata),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_valid      (mem_valid),
      .mem_rdata      (mem_rdata),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
      m_hits   = '0;
      m_misses = '0;
   endtask

   // Backing memory returns the word address itself as data.
   task automatic do_read(input logic [31:0] a, input int gap_pct, input int rst_after);
      logic [7:0]  idx;
      logic [19:0] tg;
      logic [31:0] base;
      logic        exp_hit;
      int          beat;
      int          cyc;
      idx     = a[11:4];
      tg      = a[31:12];
      base    = {a[31:4], 4'h0};
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);

      check("ready_idle", {31'd0, cpu_ready}, 32'd1);
      cpu_req  = 1'b1;
      cpu_addr = a;
      @(posedge clk); #1;
      cpu_req  = 1'b0;
      cpu_addr = $urandom;
      check("lookup_busy", {31'd0, cpu_ready}, 32'd0);
      @(posedge clk); #1;

      if (exp_hit) begin
         m_hits = m_hits + 32'd1;
      end else begin
         m_misses = m_misses + 32'd1;
         check("refill_mem_req", {31'd0, mem_req}, 32'd1);
         check("refill_mem_addr", mem_addr, base);
         beat = 0;
         cyc  = 0;
         while (beat < 16 && cyc < 400) begin
            if (rst_after >= 0 && beat == rst_after) begin
               reset     = 1'b1;
               mem_valid = 1'b1;
               mem_rdata = $urandom;
               @(posedge clk); #1;
               reset     = 1'b0;
               mem_valid = 1'b0;
               model_reset();
               check("rst_mem_req", {31'd0, mem_req}, 32'd0);
               check("rst_resp", {31'd0, cpu_resp_valid}, 32'd0);
               check("rst_ready", {31'd0, cpu_ready}, 32'd1);
               check("rst_hits", hit_count, 32'd0);
               check("rst_misses", miss_count, 32'd0);
               check("rst_rdata", cpu_rdata, 32'd0);
               return;
            end
            mem_valid = ($urandom_range(99) >= gap_pct);
            mem_rdata = mem_valid ? base + beat : $urandom;
            cpu_req   = ($urandom_range(3) == 0);
            cpu_addr  = $urandom;
            check("no_early_resp", {31'd0, cpu_resp_valid}, 32'd0);
            @(posedge clk); #1;
            if (mem_valid) beat++;
            cyc++;
            if (beat < 16) check("mem_req_held", {31'd0, mem_req}, 32'd1);
         end
         mem_valid = 1'b0;
         cpu_req   = 1'b0;
         check("burst_done", beat, 32'd16);
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
      end

      check("resp_valid", {31'd0, cpu_resp_valid}, 32'd1);
      check("resp_rdata", cpu_rdata, a);
      check("resp_mem_req", {31'd0, mem_req}, 32'd0);
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
      @(posedge clk); #1;
      check("resp_pulse", {31'd0, cpu_resp_valid}, 32'd0);
      check("rdata_hold", cpu_rdata, a);
   endtask

   task automatic idle_junk(input int n);
      for (int i = 0; i < n; i++) begin
         mem_valid = 1'b1;
         mem_rdata = $urandom;
         @(posedge clk); #1;
      end
      mem_valid = 1'b0;
      check("idle_counts", hit_count + miss_count, m_hits + m_misses);
   endtask

   initial begin
      logic [19:0] tg;
      logic [7:0]  idx;
      logic [31:0] a;
      logic [7:0]  idx_pool [4];
      reset     = 1'b1;
      cpu_req   = 1'b0;
      cpu_addr  = '0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      model_reset();
      idx_pool[0] = 8'h23; idx_pool[1] = 8'h24; idx_pool[2] = 8'h05; idx_pool[3] = 8'hFF;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("reset_ready", {31'd0, cpu_ready}, 32'd1);
      check("reset_resp", {31'd0, cpu_resp_valid}, 32'd0);
      check("reset_rdata", cpu_rdata, 32'd0);
      check("reset_mem_req", {31'd0, mem_req}, 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      check("reset_hits", hit_count, 32'd0);
      check("reset_misses", miss_count, 32'd0);

      do_read(32'h0000_1234, 0, -1);   // cold miss
      do_read(32'h0000_123F, 0, -1);   // hit
      do_read(32'h0001_1230, 0, -1);   // conflict miss
      do_read(32'h0000_1234, 0, -1);   // evicted, miss again
      do_read(32'h0000_5678, 60, -1);  // gapped burst
      idle_junk(4);
      do_read(32'h0000_567A, 0, -1);   // line survives stray mem_valid
      do_read(32'h0000_2000, 0, 7);    // reset after 7 beats
      do_read(32'h0000_2000, 30, -1);  // line left invalid
      do_read(32'h0000_2005, 0, -1);

      for (int n = 0; n < 40; n++) begin
         tg  = 20'($urandom_range(3));
         idx = idx_pool[$urandom_range(3)];
         a   = {tg, idx, 4'($urandom_range(15))};
         if ($urandom_range(4) == 0) idle_junk(int'($urandom_range(3)) + 1);
         do_read(a, int'($urandom_range(50)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
